// File: rtl/vend_pkg.sv
// Shared types for the multi-slot vending controller: FSM states, change-coin codes, coin values.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        CHANGE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_e;

    localparam int unsigned VAL_W       = 3;
    localparam int unsigned VAL_NICKEL  = 1;
    localparam int unsigned VAL_DIME    = 2;
    localparam int unsigned VAL_QUARTER = 5;

    // Value of a change coin in 5c units.
    function automatic logic [VAL_W-1:0] coin_value(input coin_e c);
        logic [VAL_W-1:0] v;
        v = '0;
        case (c)
            COIN_NICKEL:  v = VAL_W'(VAL_NICKEL);
            COIN_DIME:    v = VAL_W'(VAL_DIME);
            COIN_QUARTER: v = VAL_W'(VAL_QUARTER);
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_price_table.sv
// Per-slot price registers: synchronous write, asynchronous read by slot select.
module vend_price_table #(
    parameter int unsigned N         = 6,
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned PRICE_RST = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [N-1:0]     wr_data,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [N-1:0]     rd_data_c
);

    logic [N-1:0] price_q [SLOTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                price_q[i] <= N'(PRICE_RST);
            end
        end else if (wr_en && (32'(wr_sel) < SLOTS)) begin
            price_q[wr_sel] <= wr_data;
        end
    end

    // Unpopulated slot selects read as zero; the controller refuses them separately.
    always_comb begin
        rd_data_c = '0;
        if (32'(rd_sel) < SLOTS) begin
            rd_data_c = price_q[rd_sel];
        end
    end

endmodule

// File: rtl/vend_multi_slot.sv
// Multi-product vending controller: credit accumulation, vend handshake, largest-first change payout.
// Optional per-slot stock counters and sold_out flag when SOLD_OUT_EN is defined.
module vend_multi_slot
    import vend_pkg::*;
#(
    parameter int unsigned N         = 6,
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned PRICE_RST = 11
`ifdef SOLD_OUT_EN
    ,
    parameter int unsigned INV_W     = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nickel,
    input  logic             dime,
    input  logic             quarter,
    input  logic             dispense,
    input  logic [SEL_W-1:0] sel,
    input  logic             done,
    input  logic             price_ld,
    input  logic [N-1:0]     price_in,
`ifdef SOLD_OUT_EN
    input  logic             stock_ld,
    output logic             sold_out,
`endif
    output logic             serve,
    output logic             change,
    output logic [1:0]       change_coin,
    output logic             coin_reject,
    output logic [N-1:0]     amount
);

    state_e       state_q, state_d;
    logic [N-1:0] amount_q, amount_d;
    logic [N-1:0] price_q, price_d;
    logic         serve_q, serve_d;
    logic         change_q, change_d;
    coin_e        coin_q, coin_d;
    logic         reject_q, reject_d;

    logic [N-1:0]     price_rd_c;
    logic             price_wr_c;
    logic             slot_ok_c;
    logic             stock_ok_c;
    logic             coin_any_c;
    logic             coin_multi_c;
    logic [VAL_W-1:0] coin_val_c;
    logic [N:0]       coin_sum_c;
    logic [N-1:0]     remain_c;
    coin_e            pick_c;

    assign price_wr_c = (state_q == IDLE) && price_ld;
    assign slot_ok_c  = (32'(sel) < SLOTS);

    vend_price_table #(
        .N         (N),
        .SLOTS     (SLOTS),
        .SEL_W     (SEL_W),
        .PRICE_RST (PRICE_RST)
    ) u_price (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (price_wr_c),
        .wr_sel    (sel),
        .wr_data   (price_in),
        .rd_sel    (sel),
        .rd_data_c (price_rd_c)
    );

`ifdef SOLD_OUT_EN
    logic [INV_W-1:0] stock_q [SLOTS];
    logic [SEL_W-1:0] sel_q, sel_d;

    // Stock counters: loaded in IDLE, decremented when the serve is acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                stock_q[i] <= '0;
            end
        end else begin
            sel_q <= sel_d;
            if ((state_q == IDLE) && stock_ld && slot_ok_c) begin
                stock_q[sel] <= price_in[INV_W-1:0];
            end else if ((state_q == SERVE) && done && (stock_q[sel_q] != '0)) begin
                stock_q[sel_q] <= stock_q[sel_q] - INV_W'(1);
            end
        end
    end

    assign stock_ok_c = slot_ok_c && (stock_q[sel] != '0);
    assign sold_out   = (stock_q[sel] == '0);
`else
    assign stock_ok_c = 1'b1;
`endif

    // Coin priority: quarter > dime > nickel; overflow detected on the extra carry bit.
    always_comb begin
        coin_any_c   = nickel | dime | quarter;
        coin_multi_c = (nickel & dime) | (nickel & quarter) | (dime & quarter);
        if (quarter) begin
            coin_val_c = VAL_W'(VAL_QUARTER);
        end else if (dime) begin
            coin_val_c = VAL_W'(VAL_DIME);
        end else if (nickel) begin
            coin_val_c = VAL_W'(VAL_NICKEL);
        end else begin
            coin_val_c = '0;
        end
        coin_sum_c = {1'b0, amount_q} + (N+1)'(coin_val_c);
    end

    always_comb begin
        if (amount_q >= N'(VAL_QUARTER)) begin
            pick_c = COIN_QUARTER;
        end else if (amount_q >= N'(VAL_DIME)) begin
            pick_c = COIN_DIME;
        end else begin
            pick_c = COIN_NICKEL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            amount_q <= '0;
            price_q  <= '0;
            serve_q  <= 1'b0;
            change_q <= 1'b0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            amount_q <= amount_d;
            price_q  <= price_d;
            serve_q  <= serve_d;
            change_q <= change_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        amount_d = amount_q;
        price_d  = price_q;
        serve_d  = serve_q;
        change_d = change_q;
        coin_d   = coin_q;
        reject_d = 1'b0;
        remain_c = '0;
`ifdef SOLD_OUT_EN
        sel_d    = sel_q;
`endif
        case (state_q)
            IDLE: begin
                if (coin_any_c) begin
                    if (coin_sum_c[N]) begin
                        reject_d = 1'b1;
                    end else begin
                        amount_d = coin_sum_c[N-1:0];
                    end
                    if (coin_multi_c) begin
                        reject_d = 1'b1;
                    end
                end
                // Vend decision uses the pre-coin credit; price is captured for the debit.
                if (dispense && slot_ok_c && stock_ok_c && (amount_q >= price_rd_c)) begin
                    state_d = SERVE;
                    serve_d = 1'b1;
                    price_d = price_rd_c;
`ifdef SOLD_OUT_EN
                    sel_d   = sel;
`endif
                end
            end
            SERVE: begin
                reject_d = coin_any_c;
                if (done) begin
                    remain_c = amount_q - price_q;
                    amount_d = remain_c;
                    serve_d  = 1'b0;
                    state_d  = (remain_c != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                reject_d = coin_any_c;
                if (!change_q) begin
                    if (amount_q == '0) begin
                        state_d = IDLE;
                        coin_d  = COIN_NONE;
                    end else begin
                        change_d = 1'b1;
                        coin_d   = pick_c;
                    end
                end else if (done) begin
                    remain_c = amount_q - N'(coin_value(coin_q));
                    amount_d = remain_c;
                    change_d = 1'b0;
                    coin_d   = COIN_NONE;
                    if (remain_c == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serve_d  = 1'b0;
                change_d = 1'b0;
                coin_d   = COIN_NONE;
            end
        endcase
    end

    assign serve       = serve_q;
    assign change      = change_q;
    assign change_coin = coin_q;
    assign coin_reject = reject_q;
    assign amount      = amount_q;

endmodule

// File: tb/tb_vend_multi_slot.sv
// Self-checking bench for vend_multi_slot: reference credit model plus a queue of expected change coins.
module tb_vend_multi_slot;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
    logic       dispense = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       done = 1'b0;
    logic       price_ld = 1'b0;
    logic [5:0] price_in = 6'd0;
    logic       serve, change, coin_reject;
    logic [1:0] change_coin;
    logic [5:0] amount;
`ifdef SOLD_OUT_EN
    logic       stock_ld = 1'b0;
    logic       sold_out;
`endif

    int total = 0;
    int bad   = 0;
    int m_amt;
    int m_price [4];
`ifdef SOLD_OUT_EN
    int m_stock [4];
`endif
    int exp_q [$];

    vend_multi_slot dut (
        .clk         (clk),
        .rst         (rst),
        .nickel      (nickel),
        .dime        (dime),
        .quarter     (quarter),
        .dispense    (dispense),
        .sel         (sel),
        .done        (done),
        .price_ld    (price_ld),
        .price_in    (price_in),
`ifdef SOLD_OUT_EN
        .stock_ld    (stock_ld),
        .sold_out    (sold_out),
`endif
        .serve       (serve),
        .change      (change),
        .change_coin (change_coin),
        .coin_reject (coin_reject),
        .amount      (amount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int coin_val(input int code);
        return (code == 3) ? 5 : (code == 2) ? 2 : (code == 1) ? 1 : 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        m_amt = 0;
        for (int i = 0; i < 4; i++) m_price[i] = 11;
`ifdef SOLD_OUT_EN
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); price_in = 6'd15; stock_ld = 1'b1;
            step();
            stock_ld = 1'b0;
            m_stock[i] = 15;
        end
`endif
    endtask

    // Insert coins in IDLE; model applies priority, overflow and rejection.
    task automatic drop(input bit n, input bit d, input bit q);
        int v;
        bit rej;
        v   = q ? 5 : d ? 2 : n ? 1 : 0;
        rej = (int'(n) + int'(d) + int'(q)) > 1;
        if (m_amt + v > 63) rej = 1'b1;
        else m_amt += v;
        nickel = n; dime = d; quarter = q;
        step();
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
        check("coin_amount", 32'(amount), 32'(m_amt));
        check("coin_reject", 32'(coin_reject), 32'(rej));
    endtask

    task automatic load_price(input int s, input int p);
        sel = 2'(s); price_in = 6'(p); price_ld = 1'b1;
        step();
        price_ld = 1'b0;
        m_price[s] = p;
    endtask

    // Full vend transaction with serve and change handshakes.
    task automatic vend(input int s, input bit coin_in_serve);
        bit ok;
        int rem;
        int e;
        ok = (m_amt >= m_price[s]);
`ifdef SOLD_OUT_EN
        ok = ok && (m_stock[s] != 0);
`endif
        sel = 2'(s); dispense = 1'b1;
        step();
        dispense = 1'b0;
        check("serve_rise", 32'(serve), 32'(ok));
        if (!ok) begin
            check("ignored_amount", 32'(amount), 32'(m_amt));
            return;
        end
        rem = m_amt - m_price[s];
        while (rem > 0) begin
            e = (rem >= 5) ? 3 : (rem >= 2) ? 2 : 1;
            exp_q.push_back(e);
            rem -= coin_val(e);
        end
        step();
        check("serve_hold", 32'(serve), 32'd1);
        if (coin_in_serve) begin
            quarter = 1'b1;
            step();
            quarter = 1'b0;
            check("serve_coin_rej", 32'(coin_reject), 32'd1);
            check("serve_coin_amt", 32'(amount), 32'(m_amt));
        end
        done = 1'b1;
        step();
        done = 1'b0;
`ifdef SOLD_OUT_EN
        m_stock[s]--;
`endif
        m_amt -= m_price[s];
        check("serve_drop", 32'(serve), 32'd0);
        check("after_serve_amt", 32'(amount), 32'(m_amt));
        check("no_change_yet", 32'(change), 32'd0);
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check("change_valid", 32'(change), 32'd1);
            check("change_coin", 32'(change_coin), 32'(e));
            done = 1'b1;
            step();
            done = 1'b0;
            m_amt -= coin_val(e);
            check("change_amt", 32'(amount), 32'(m_amt));
            check("change_drop", 32'(change), 32'd0);
        end
        step();
        check("idle_amt", 32'(amount), 32'd0);
        check("idle_coin", 32'(change_coin), 32'd0);
        check("idle_serve", 32'(serve), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_amount", 32'(amount), 32'd0);
        check("rst_serve", 32'(serve), 32'd0);
        check("rst_change", 32'(change), 32'd0);
        check("rst_coin", 32'(change_coin), 32'd0);
        check("rst_reject", 32'(coin_reject), 32'd0);

        // Every slot priced 11: 10 is short, 11 is an exact vend with no change.
        repeat (5) drop(1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) vend(s, 1'b0);
        drop(1'b1, 1'b0, 1'b0);
        vend(3, 1'b0);

        do_reset();
        drop(1'b1, 1'b0, 1'b0);
        drop(1'b0, 1'b1, 1'b0);
        vend(0, 1'b0);
        step();
        check("short_serve", 32'(serve), 32'd0);

        do_reset();
        drop(1'b0, 1'b1, 1'b0);
        drop(1'b0, 1'b0, 1'b1);
        drop(1'b0, 1'b0, 1'b1);
        vend(0, 1'b0);

        load_price(2, 4);
        drop(1'b0, 1'b0, 1'b1);
        vend(2, 1'b0);

        // Overflow at 2^N-1 and a coin refused while serving; change 52 = 10 quarters + dime.
        repeat (12) drop(1'b0, 1'b0, 1'b1);
        drop(1'b0, 1'b0, 1'b1);
        repeat (3) drop(1'b1, 1'b0, 1'b0);
        drop(1'b1, 1'b0, 1'b0);
        step();
        check("reject_pulse", 32'(coin_reject), 32'd0);
        vend(0, 1'b1);

        drop(1'b1, 1'b1, 1'b1);
        drop(1'b1, 1'b1, 1'b0);
        drop(1'b0, 1'b1, 1'b1);

        // Coin in the dispense cycle: compare uses the pre-coin credit.
        do_reset();
        repeat (5) drop(1'b0, 1'b1, 1'b0);
        sel = 2'd0; dispense = 1'b1; nickel = 1'b1;
        step();
        dispense = 1'b0; nickel = 1'b0;
        m_amt += 1;
        check("coin_disp_serve", 32'(serve), 32'd0);
        check("coin_disp_amt", 32'(amount), 32'(m_amt));
        vend(0, 1'b0);

        done = 1'b1;
        step();
        done = 1'b0;
        check("idle_done_amt", 32'(amount), 32'd0);
        check("idle_done_chg", 32'(change), 32'd0);

`ifdef SOLD_OUT_EN
        sel = 2'd1; price_in = 6'd1; stock_ld = 1'b1;
        step();
        stock_ld = 1'b0;
        m_stock[1] = 1;
        check("stock_loaded", 32'(sold_out), 32'd0);
        repeat (3) drop(1'b0, 1'b0, 1'b1);
        vend(1, 1'b0);
        repeat (3) drop(1'b0, 1'b0, 1'b1);
        vend(1, 1'b0);
        sel = 2'd1;
        #1;
        check("sold_out", 32'(sold_out), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
